// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 butterfly datapath.
package fft_pkg;

  // Wide signed intermediate; comfortably holds I_WIDTH+2 for any practical
  // sample width.
  localparam int WIDE_W = 32;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Index of the lane this lane is paired with inside its 2*stride block.
  function automatic int bfly_partner(input int lane, input int stride);
    int p;
    p = lane % (2 * stride);
    return (p < stride) ? lane + stride : lane - stride;
  endfunction

  // True for the upper half of a block, which produces the difference.
  function automatic bit bfly_is_diff(input int lane, input int stride);
    return (lane % (2 * stride)) >= stride;
  endfunction

  // Optional divide-by-2 (round half up), then clamp to o_width signed range.
  function automatic wide_t sat_round(input wide_t r, input int o_width,
                                      input logic scale, output logic clamped);
    wide_t v;
    wide_t v_max;
    wide_t v_min;
    v       = scale ? ((r + wide_t'(1)) >>> 1) : r;
    v_max   = (wide_t'(1) <<< (o_width - 1)) - wide_t'(1);
    v_min   = -v_max - wide_t'(1);
    clamped = 1'b0;
    if (v > v_max) begin
      v       = v_max;
      clamped = 1'b1;
    end else if (v < v_min) begin
      v       = v_min;
      clamped = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/fft_bfly_stage_if.sv
// Beat-level handshake bundle between a butterfly stage and its neighbours.
interface fft_bfly_stage_if #(
  parameter int I_WIDTH = 13,
  parameter int O_WIDTH = 14,
  parameter int N_LANES = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      scale_en;
  logic signed [I_WIDTH-1:0] din_re [0:N_LANES-1];
  logic signed [I_WIDTH-1:0] din_im [0:N_LANES-1];
  logic                      out_valid;
  logic                      out_ready;
  logic signed [O_WIDTH-1:0] dout_re [0:N_LANES-1];
  logic signed [O_WIDTH-1:0] dout_im [0:N_LANES-1];

  modport master (
    output in_valid, scale_en, din_re, din_im, out_ready,
    input  in_ready, out_valid, dout_re, dout_im
  );

  modport slave (
    input  in_valid, scale_en, din_re, din_im, out_ready,
    output in_ready, out_valid, dout_re, dout_im
  );
endinterface

// File: rtl/fft_bfly_lane.sv
// One complex butterfly lane: add/sub into S1, round/saturate into S2.
module fft_bfly_lane
  import fft_pkg::*;
#(
  parameter int I_WIDTH = 13,
  parameter int O_WIDTH = 14,
  parameter bit IS_DIFF = 1'b0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      adv,
  input  logic                      s1_scale,
  input  logic signed [I_WIDTH-1:0] a_re,
  input  logic signed [I_WIDTH-1:0] a_im,
  input  logic signed [I_WIDTH-1:0] b_re,
  input  logic signed [I_WIDTH-1:0] b_im,
  output logic signed [O_WIDTH-1:0] dout_re,
  output logic signed [O_WIDTH-1:0] dout_im,
  output logic                      clamp
);

  typedef logic signed [I_WIDTH:0]   sum_t;
  typedef logic signed [O_WIDTH-1:0] out_t;

  sum_t  r_re_d, r_im_d;
  sum_t  r_re_q, r_im_q;
  wide_t v_re, v_im;
  logic  clamp_re, clamp_im;

  // Exact sum (lower half of block) or difference (upper half), one bit wider.
  always_comb begin
    r_re_d = IS_DIFF ? (sum_t'(a_re) - sum_t'(b_re)) : (sum_t'(a_re) + sum_t'(b_re));
    r_im_d = IS_DIFF ? (sum_t'(a_im) - sum_t'(b_im)) : (sum_t'(a_im) + sum_t'(b_im));
  end

  // S1: hold the exact butterfly result while downstream stalls.
  always_ff @(posedge clk) begin
    // NOTE: data registers are reset too, so dout reads 0 right after reset
    // rather than whatever the datapath last held.
    if (!rstn) begin
      // NOTE: state is always written with <= so every register samples the
      // pre-edge values, independent of block ordering.
      r_re_q <= '0;
      r_im_q <= '0;
    end else if (adv) begin
      r_re_q <= r_re_d;
      r_im_q <= r_im_d;
    end
  end

  // Scale/round/saturate the S1 values; flag if either component clamped.
  always_comb begin
    v_re  = sat_round(wide_t'(r_re_q), O_WIDTH, s1_scale, clamp_re);
    v_im  = sat_round(wide_t'(r_im_q), O_WIDTH, s1_scale, clamp_im);
    clamp = clamp_re | clamp_im;
  end

  // S2: output register; stable under stall.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout_re <= '0;
      dout_im <= '0;
    end else if (adv) begin
      dout_re <= out_t'(v_re);
      dout_im <= out_t'(v_im);
    end
  end

endmodule

// File: rtl/fft_bfly_stage.sv
// Radix-2 butterfly stage: N_LANES lanes, 2-deep pipeline, valid/ready flow
// control and a sticky saturation flag.
module fft_bfly_stage
  import fft_pkg::*;
#(
  parameter int I_WIDTH = 13,
  parameter int O_WIDTH = 14,
  parameter int N_LANES = 16,
  parameter int STRIDE  = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  fft_bfly_stage_if.slave      bus,
  input  logic                 ovf_clr,
  output logic                 ovf_sticky
);

  logic                      stall;
  logic                      adv;
  logic                      s1_valid;
  logic                      s1_scale;
  logic                      lane_clamp [0:N_LANES-1];
  logic                      any_clamp;
  logic                      sat_event;
  logic signed [O_WIDTH-1:0] dout_re_w [0:N_LANES-1];
  logic signed [O_WIDTH-1:0] dout_im_w [0:N_LANES-1];

  // Both stages move together; only a held output beat freezes them.
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign adv          = ~stall;
  assign bus.in_ready = adv;

  // OR of per-lane clamp flags for the beat currently in S1.
  always_comb begin
    // NOTE: default first so every path assigns any_clamp and no latch forms.
    any_clamp = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      any_clamp = any_clamp | lane_clamp[i];
    end
  end

  assign sat_event = s1_valid & adv & any_clamp;

  // Valid pipeline, per-beat scale flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid      <= 1'b0;
      s1_scale      <= 1'b0;
      bus.out_valid <= 1'b0;
      ovf_sticky    <= 1'b0;
    end else begin
      if (adv) begin
        s1_valid      <= bus.in_valid;
        s1_scale      <= bus.scale_en;
        bus.out_valid <= s1_valid;
      end
      ovf_sticky <= (ovf_sticky & ~ovf_clr) | sat_event;
    end
  end

  // One lane per output; lower index of each pair is always the 'a' operand.
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    localparam bit DIFF = bfly_is_diff(i, STRIDE);
    localparam int LO   = DIFF ? bfly_partner(i, STRIDE) : i;
    localparam int HI   = DIFF ? i : bfly_partner(i, STRIDE);

    fft_bfly_lane #(
      .I_WIDTH (I_WIDTH),
      .O_WIDTH (O_WIDTH),
      .IS_DIFF (DIFF)
    ) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .adv      (adv),
      .s1_scale (s1_scale),
      .a_re     (bus.din_re[LO]),
      .a_im     (bus.din_im[LO]),
      .b_re     (bus.din_re[HI]),
      .b_im     (bus.din_im[HI]),
      .dout_re  (dout_re_w[i]),
      .dout_im  (dout_im_w[i]),
      .clamp    (lane_clamp[i])
    );
  end

  assign bus.dout_re = dout_re_w;
  assign bus.dout_im = dout_im_w;

endmodule

// File: tb/tb_fft_bfly_stage.sv
// Scoreboard bench: three stage configurations driven in lockstep
// (A: default, B: O_WIDTH=13, C: STRIDE=4) and checked against a
// lane-arithmetic reference model.
module tb_fft_bfly_stage;

  localparam int NL = 16;
  localparam int IW = 13;
  typedef logic [NL*16-1:0] vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ovf_clr = 1'b0;
  logic sticky_a, sticky_b, sticky_c;

  always #5 clk = ~clk;

  fft_bfly_stage_if #(.I_WIDTH(IW), .O_WIDTH(14), .N_LANES(NL)) bus_a ();
  fft_bfly_stage_if #(.I_WIDTH(IW), .O_WIDTH(13), .N_LANES(NL)) bus_b ();
  fft_bfly_stage_if #(.I_WIDTH(IW), .O_WIDTH(14), .N_LANES(NL)) bus_c ();

  fft_bfly_stage #(.I_WIDTH(IW), .O_WIDTH(14), .N_LANES(NL), .STRIDE(2)) dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a), .ovf_clr(ovf_clr), .ovf_sticky(sticky_a));
  fft_bfly_stage #(.I_WIDTH(IW), .O_WIDTH(13), .N_LANES(NL), .STRIDE(2)) dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b), .ovf_clr(ovf_clr), .ovf_sticky(sticky_b));
  fft_bfly_stage #(.I_WIDTH(IW), .O_WIDTH(14), .N_LANES(NL), .STRIDE(4)) dut_c (
    .clk(clk), .rstn(rstn), .bus(bus_c), .ovf_clr(ovf_clr), .ovf_sticky(sticky_c));

  int checks = 0;
  int errors = 0;

  vec_t q_re [3][$];
  vec_t q_im [3][$];

  bit drv_valid, drv_scale, drv_ready, drv_clr, drv_rstn;
  int drv_re [NL];
  int drv_im [NL];
  bit accepted;

  task automatic check(input bit ok, input string name, input int got, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int stride_of(input int d);
    return (d == 2) ? 4 : 2;
  endfunction

  function automatic int ow_of(input int d);
    return (d == 1) ? 13 : 14;
  endfunction

  // Reference: pair sum/difference, optional halve-with-round-up, clamp.
  function automatic void model(input int x_re [NL], input int x_im [NL], input bit scale,
                                input int stride, input int ow,
                                output vec_t e_re, output vec_t e_im);
    int hi, lo, r, v;
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    e_re = '0;
    e_im = '0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NL; i++) begin
        int pos;
        pos = i % (2 * stride);
        if (c == 0) r = (pos < stride) ? x_re[i] + x_re[i + stride] : x_re[i - stride] - x_re[i];
        else        r = (pos < stride) ? x_im[i] + x_im[i + stride] : x_im[i - stride] - x_im[i];
        v = scale ? ((r + 1) >>> 1) : r;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        if (c == 0) e_re[i*16 +: 16] = 16'(v);
        else        e_im[i*16 +: 16] = 16'(v);
      end
    end
  endfunction

  function automatic int lane_re(input int d, input int i);
    case (d)
      0:       return int'(bus_a.dout_re[i]);
      1:       return int'(bus_b.dout_re[i]);
      default: return int'(bus_c.dout_re[i]);
    endcase
  endfunction

  function automatic int lane_im(input int d, input int i);
    case (d)
      0:       return int'(bus_a.dout_im[i]);
      1:       return int'(bus_b.dout_im[i]);
      default: return int'(bus_c.dout_im[i]);
    endcase
  endfunction

  function automatic bit ovalid(input int d);
    case (d)
      0:       return bus_a.out_valid;
      1:       return bus_b.out_valid;
      default: return bus_c.out_valid;
    endcase
  endfunction

  // Drive one cycle's inputs just after the edge; record accepted beats.
  task automatic tick();
    vec_t er, ei;
    @(posedge clk);
    #2;
    rstn    = drv_rstn;
    ovf_clr = drv_clr;
    bus_a.in_valid = drv_valid; bus_a.scale_en = drv_scale; bus_a.out_ready = drv_ready;
    bus_b.in_valid = drv_valid; bus_b.scale_en = drv_scale; bus_b.out_ready = drv_ready;
    bus_c.in_valid = drv_valid; bus_c.scale_en = drv_scale; bus_c.out_ready = drv_ready;
    for (int i = 0; i < NL; i++) begin
      bus_a.din_re[i] = IW'(drv_re[i]); bus_a.din_im[i] = IW'(drv_im[i]);
      bus_b.din_re[i] = IW'(drv_re[i]); bus_b.din_im[i] = IW'(drv_im[i]);
      bus_c.din_re[i] = IW'(drv_re[i]); bus_c.din_im[i] = IW'(drv_im[i]);
    end
    #1;
    accepted = drv_valid && drv_rstn && bus_a.in_ready;
    if (accepted) begin
      for (int d = 0; d < 3; d++) begin
        model(drv_re, drv_im, drv_scale, stride_of(d), ow_of(d), er, ei);
        q_re[d].push_back(er);
        q_im[d].push_back(ei);
      end
    end
  endtask

  task automatic clear_data();
    for (int i = 0; i < NL; i++) begin
      drv_re[i] = 0;
      drv_im[i] = 0;
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NL; i++) begin
      drv_re[i] = int'($urandom_range(8191)) - 4096;
      drv_im[i] = int'($urandom_range(8191)) - 4096;
    end
  endtask

  // Monitor: every transferred output beat must match the oldest expectation.
  always @(negedge clk) begin
    vec_t er, ei;
    int bad, got, exp;
    if (rstn && bus_a.out_ready) begin
      for (int d = 0; d < 3; d++) begin
        if (ovalid(d)) begin
          if (q_re[d].size() == 0) begin
            check(1'b0, $sformatf("stale_beat_dut%0d queue_depth", d), 1, 0);
          end else begin
            er  = q_re[d].pop_front();
            ei  = q_im[d].pop_front();
            bad = -1;
            got = 0;
            exp = 0;
            for (int i = NL - 1; i >= 0; i--) begin
              if (lane_re(d, i) != int'($signed(er[i*16 +: 16]))) begin
                bad = i; got = lane_re(d, i); exp = int'($signed(er[i*16 +: 16]));
              end else if (lane_im(d, i) != int'($signed(ei[i*16 +: 16]))) begin
                bad = 100 + i; got = lane_im(d, i); exp = int'($signed(ei[i*16 +: 16]));
              end
            end
            check(bad < 0, $sformatf("beat_dut%0d_lane%0d", d, bad), got, exp);
          end
        end
      end
    end
  end

  int bp_re [3][NL];
  int bp_im [3][NL];
  int snap [NL];
  int sent, nbad;
  bit seen;
  int ramp_exp [NL] = '{4, 6, 8, 10, -4, -4, -4, -4, 20, 22, 24, 26, -4, -4, -4, -4};

  initial begin
    drv_valid = 0; drv_scale = 0; drv_ready = 1; drv_clr = 0; drv_rstn = 0;
    clear_data();

    // Reset state
    tick(); tick();
    drv_rstn = 1;
    tick();
    check(bus_a.out_valid == 1'b0, "rst_out_valid", int'(bus_a.out_valid), 0);
    check(bus_a.in_ready == 1'b1, "rst_in_ready", int'(bus_a.in_ready), 1);
    check(sticky_b == 1'b0, "rst_sticky", int'(sticky_b), 0);
    check(lane_re(0, 0) == 0, "rst_dout", lane_re(0, 0), 0);

    // Basic add/sub, latency and single-cycle out_valid
    clear_data();
    drv_re[0] = 100; drv_re[1] = 20; drv_re[2] = -7; drv_re[3] = 5;
    drv_valid = 1; tick();
    drv_valid = 0; tick();
    check(bus_a.out_valid == 1'b0, "basic_not_yet", int'(bus_a.out_valid), 0);
    tick();
    check(bus_a.out_valid == 1'b1, "basic_latency2", int'(bus_a.out_valid), 1);
    check(lane_re(0, 0) == 93,  "basic_lane0", lane_re(0, 0), 93);
    check(lane_re(0, 1) == 25,  "basic_lane1", lane_re(0, 1), 25);
    check(lane_re(0, 2) == 107, "basic_lane2", lane_re(0, 2), 107);
    check(lane_re(0, 3) == 15,  "basic_lane3", lane_re(0, 3), 15);
    tick();
    check(bus_a.out_valid == 1'b0, "basic_one_cycle", int'(bus_a.out_valid), 0);

    // Rounding, back-to-back beats
    clear_data();
    drv_scale = 1; drv_re[0] = 3; drv_re[2] = 2; drv_valid = 1; tick();
    drv_re[0] = -3; drv_re[2] = 0; tick();
    drv_valid = 0; drv_scale = 0; tick();
    check(lane_re(0, 0) == 3, "round_pos_sum", lane_re(0, 0), 3);
    check(lane_re(0, 2) == 1, "round_pos_diff", lane_re(0, 2), 1);
    tick();
    check(lane_re(0, 0) == -1, "round_neg", lane_re(0, 0), -1);

    // Saturation and sticky flag
    clear_data();
    drv_re[0] = 4095; drv_re[2] = 4095; drv_valid = 1; tick();
    drv_valid = 0; tick();
    drv_clr = 1; tick();
    check(lane_re(1, 0) == 4095, "sat_clamp_hi", lane_re(1, 0), 4095);
    check(lane_re(1, 2) == 0, "sat_diff", lane_re(1, 2), 0);
    check(sticky_b == 1'b1, "sticky_set", int'(sticky_b), 1);
    check(sticky_a == 1'b0, "sticky_wide_out", int'(sticky_a), 0);
    drv_clr = 0; tick();
    check(sticky_b == 1'b0, "sticky_clear", int'(sticky_b), 0);
    drv_valid = 1; tick();
    drv_valid = 0; drv_clr = 1; tick();
    drv_clr = 0; tick();
    check(sticky_b == 1'b1, "sticky_clr_and_set", int'(sticky_b), 1);
    tick();

    // Backpressure: 5 stalled cycles, 3 beats offered
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < NL; i++) begin
        bp_re[b][i] = int'($urandom_range(8191)) - 4096;
        bp_im[b][i] = int'($urandom_range(8191)) - 4096;
      end
    drv_ready = 0; sent = 0;
    for (int c = 0; c < 5; c++) begin
      drv_valid = (sent < 3);
      if (sent < 3) begin drv_re = bp_re[sent]; drv_im = bp_im[sent]; end
      tick();
      if (accepted) sent++;
      if (c == 2) for (int i = 0; i < NL; i++) snap[i] = lane_re(0, i);
    end
    check(sent == 2, "bp_accepted_while_stalled", sent, 2);
    check(bus_a.in_ready == 1'b0, "bp_in_ready_low", int'(bus_a.in_ready), 0);
    nbad = 0;
    for (int i = 0; i < NL; i++) if (lane_re(0, i) != snap[i]) nbad++;
    check(nbad == 0, "bp_dout_stable_lanes_changed", nbad, 0);
    drv_ready = 1;
    for (int c = 0; c < 10 && sent < 3; c++) begin
      drv_valid = 1; drv_re = bp_re[sent]; drv_im = bp_im[sent];
      tick();
      if (accepted) sent++;
    end
    drv_valid = 0;
    check(sent == 3, "bp_all_accepted", sent, 3);
    repeat (4) tick();

    // Reset with two beats in flight
    drv_ready = 0; rand_data(); drv_valid = 1;
    tick(); rand_data(); tick();
    drv_valid = 0; drv_rstn = 0; tick();
    for (int d = 0; d < 3; d++) begin q_re[d].delete(); q_im[d].delete(); end
    drv_rstn = 1; drv_ready = 1; tick();
    check(bus_a.out_valid == 1'b0, "midrst_out_valid", int'(bus_a.out_valid), 0);
    check(sticky_b == 1'b0, "midrst_sticky", int'(sticky_b), 0);
    nbad = 0;
    for (int i = 0; i < NL; i++) if (lane_re(0, i) != 0 || lane_im(0, i) != 0) nbad++;
    check(nbad == 0, "midrst_dout_nonzero_lanes", nbad, 0);
    seen = 0;
    repeat (6) begin tick(); seen |= bus_a.out_valid | bus_b.out_valid | bus_c.out_valid; end
    check(!seen, "midrst_no_stale_valid", int'(seen), 0);

    // STRIDE=4 ramp
    for (int i = 0; i < NL; i++) begin drv_re[i] = i; drv_im[i] = 0; end
    drv_valid = 1; tick();
    drv_valid = 0; tick(); tick();
    nbad = 0;
    for (int i = 0; i < NL; i++) if (lane_re(2, i) != ramp_exp[i]) nbad++;
    check(nbad == 0, "stride4_ramp_bad_lanes", nbad, 0);
    tick();

    // Random traffic with random backpressure and scaling
    for (int n = 0; n < 300; n++) begin
      rand_data();
      drv_valid = ($urandom_range(3) != 0);
      drv_ready = ($urandom_range(3) != 0);
      drv_scale = $urandom_range(1) != 0;
      drv_clr   = ($urandom_range(7) == 0);
      tick();
    end

    // Drain with a bounded cycle budget
    drv_valid = 0; drv_ready = 1; drv_clr = 0;
    for (int c = 0; c < 20; c++) begin
      if (q_re[0].size() == 0 && q_re[1].size() == 0 && q_re[2].size() == 0) break;
      tick();
    end
    tick();
    for (int d = 0; d < 3; d++)
      check(q_re[d].size() == 0, $sformatf("drain_dut%0d_pending", d), q_re[d].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
